sys_bridge: RTL and testbench

- Sequencing bus bridge between the multicycle CPU's processor port (PrAddr/PrDIn/PrDOut/Wen) and the memory-mapped device window at 0x7F00+.
- Decodes the device ID, drives a one-hot device select, and runs a request/ready handshake with wait states and a timeout.
- Returns read data or a bus error to the CPU controller.
- Aggregates device interrupt lines into the CP0 HWInt vector.

---
 rtl/sys_bridge_pkg.sv | 14 +
 rtl/sys_bridge_dec.sv | 28 ++
 rtl/sys_bridge.sv | 157 +++++++++++++++
 tb/tb_sys_bridge.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/sys_bridge_pkg.sv
// Shared constants and FSM encoding for the processor-to-device bus bridge.
package sys_bridge_pkg;

   localparam logic [31:0] DEV_BASE_ADDR   = 32'h7F00;
   localparam int          DEV_ADDR_WD_DEF = 4;
   localparam int          DEV_ID_WD_DEF   = 4;

   typedef enum logic [1:0] {
      BR_IDLE   = 2'd0,
      BR_ACCESS = 2'd1,
      BR_RESP   = 2'd2
   } br_state_t;

endpackage

// File: rtl/sys_bridge_dec.sv
// Combinational decode of a CPU byte address into device ID, in-window offset and a valid flag.
module sys_bridge_dec
   import sys_bridge_pkg::*;
#(
   parameter int DEV_CNT     = 2,
   parameter int DEV_ADDR_WD = DEV_ADDR_WD_DEF,
   parameter int DEV_ID_WD   = DEV_ID_WD_DEF
) (
   input  logic [31:0]            addr,
   output logic                   valid,
   output logic [DEV_ID_WD-1:0]   id,
   output logic [DEV_ADDR_WD-1:0] offset
);

   localparam int                 HI      = DEV_ADDR_WD + DEV_ID_WD;
   localparam logic [31:0]        BASE_HI = DEV_BASE_ADDR >> HI;
   localparam logic [DEV_ID_WD:0] CNT     = (DEV_ID_WD + 1)'(DEV_CNT);

   assign id     = addr[HI-1:DEV_ADDR_WD];
   assign offset = addr[DEV_ADDR_WD-1:0];

   // Only word-aligned accesses to an existing device inside the window are accepted.
   assign valid = (addr >= DEV_BASE_ADDR)
                && (addr[1:0] == 2'b00)
                && ({1'b0, id} < CNT)
                && (addr[31:HI] == BASE_HI[31-HI:0]);

endmodule

// File: rtl/sys_bridge.sv
// Sequencing bridge from the CPU processor port to the device window, with timeout and interrupt aggregation.
// Optional macro SYS_BRIDGE_INT_SYNC_EN adds a 2-flop synchronizer on each interrupt line.
module sys_bridge
   import sys_bridge_pkg::*;
#(
   parameter int DEV_CNT     = 2,
   parameter int DEV_ADDR_WD = DEV_ADDR_WD_DEF,
   parameter int DEV_ID_WD   = DEV_ID_WD_DEF,
   parameter int TIMEOUT     = 15
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    PrReq,
   input  logic                    PrWe,
   input  logic [31:0]             PrAddr,
   input  logic [31:0]             PrWD,
   output logic [31:0]             PrRD,
   output logic                    PrRdy,
   output logic                    PrErr,
   output logic [DEV_ADDR_WD-1:0]  DevAddr,
   output logic [31:0]             DevWD,
   output logic                    DevWe,
   output logic [DEV_CNT-1:0]      DevSel,
   input  logic [32*DEV_CNT-1:0]   DevRD,
   input  logic [DEV_CNT-1:0]      DevAck,
   input  logic [DEV_CNT-1:0]      DevInt,
   output logic [DEV_CNT-1:0]      HWInt
);

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   br_state_t              state, state_nxt;
   logic                   dec_valid;
   logic [DEV_ID_WD-1:0]   dec_id;
   logic [DEV_ADDR_WD-1:0] dec_off;
   logic [DEV_ID_WD-1:0]   id_q;
   logic                   we_q;
   logic [CW-1:0]          cnt;
   logic [DEV_CNT-1:0]     sel_mask;
   logic [31:0]            rd_sel;
   logic                   ack_hit;
   logic                   timeout_hit;

   sys_bridge_dec #(
      .DEV_CNT    (DEV_CNT),
      .DEV_ADDR_WD(DEV_ADDR_WD),
      .DEV_ID_WD  (DEV_ID_WD)
   ) u_dec (
      .addr  (PrAddr),
      .valid (dec_valid),
      .id    (dec_id),
      .offset(dec_off)
   );

   // NOTE: every variable written here gets a default first, so no latch is inferred.
   always_comb begin
      sel_mask = '0;
      rd_sel   = '0;
      for (int i = 0; i < DEV_CNT; i++) begin
         if (id_q == DEV_ID_WD'(i)) begin
            sel_mask[i] = 1'b1;
            rd_sel      = DevRD[32*i +: 32];
         end
      end
   end

   assign ack_hit     = |(DevAck & sel_mask);
   assign timeout_hit = (cnt == CW'(TIMEOUT - 1));

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= BR_IDLE;
      else     state <= state_nxt;
   end

   // Select and strobe derive from state, so an asynchronous reset drops them at once.
   always_comb begin
      state_nxt = state;
      DevSel    = '0;
      DevWe     = 1'b0;
      PrRdy     = 1'b0;
      case (state)
         BR_IDLE: begin
            if (PrReq) state_nxt = dec_valid ? BR_ACCESS : BR_RESP;
         end
         BR_ACCESS: begin
            DevSel = sel_mask;
            DevWe  = we_q;
            if (ack_hit || timeout_hit) state_nxt = BR_RESP;
         end
         BR_RESP: begin
            PrRdy     = 1'b1;
            state_nxt = BR_IDLE;
         end
         default: state_nxt = BR_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         PrRD    <= '0;
         PrErr   <= 1'b0;
         DevAddr <= '0;
         DevWD   <= '0;
         we_q    <= 1'b0;
         id_q    <= '0;
         cnt     <= '0;
      end else begin
         case (state)
            BR_IDLE: begin
               if (PrReq) begin
                  DevAddr <= dec_off;
                  DevWD   <= PrWD;
                  we_q    <= PrWe;
                  id_q    <= dec_id;
                  cnt     <= '0;
                  if (!dec_valid) begin
                     PrErr <= 1'b1;
                     PrRD  <= '0;
                  end
               end
            end
            BR_ACCESS: begin
               if (ack_hit) begin
                  PrRD  <= we_q ? 32'd0 : rd_sel;
                  PrErr <= 1'b0;
               end else if (timeout_hit) begin
                  PrRD  <= '0;
                  PrErr <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef SYS_BRIDGE_INT_SYNC_EN
   logic [DEV_CNT-1:0] int_meta, int_sync;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         int_meta <= '0;
         int_sync <= '0;
      end else begin
         int_meta <= DevInt;
         int_sync <= int_meta;
      end
   end

   assign HWInt = int_sync;
`else
   assign HWInt = DevInt;
`endif

endmodule

// File: tb/tb_sys_bridge.sv
// Directed, scoreboard-based testbench for sys_bridge (DEV_CNT=2, TIMEOUT=15).
module tb_sys_bridge;

   logic        clk = 1'b0;
   logic        rst;
   logic        PrReq, PrWe;
   logic [31:0] PrAddr, PrWD, PrRD;
   logic        PrRdy, PrErr;
   logic [3:0]  DevAddr;
   logic [31:0] DevWD;
   logic        DevWe;
   logic [1:0]  DevSel;
   logic [63:0] DevRD;
   logic [1:0]  DevAck, DevInt, HWInt;

   typedef struct {
      logic [31:0] rd;
      logic        err;
      int          lat;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   sys_bridge #(.DEV_CNT(2), .DEV_ADDR_WD(4), .DEV_ID_WD(4), .TIMEOUT(15)) dut (
      .clk    (clk),
      .rst    (rst),
      .PrReq  (PrReq),
      .PrWe   (PrWe),
      .PrAddr (PrAddr),
      .PrWD   (PrWD),
      .PrRD   (PrRD),
      .PrRdy  (PrRdy),
      .PrErr  (PrErr),
      .DevAddr(DevAddr),
      .DevWD  (DevWD),
      .DevWe  (DevWe),
      .DevSel (DevSel),
      .DevRD  (DevRD),
      .DevAck (DevAck),
      .DevInt (DevInt),
      .HWInt  (HWInt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One CPU transaction; the device responder asserts ack_mask after 'waits' ACCESS cycles.
   task automatic run_req(input string tag, input logic we, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [1:0] ack_mask, input int waits,
                          input logic drop_req, input logic [1:0] exp_sel, input int exp_acc,
                          input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
      exp_t e;
      int   cycles = 0;
      int   acc = 0;
      bit   got = 0;
      sb.push_back('{rd: exp_rd, err: exp_err, lat: exp_lat});
      @(negedge clk);
      PrReq  = 1'b1;
      PrWe   = we;
      PrAddr = addr;
      PrWD   = wd;
      DevAck = 2'b00;
      while (!got && cycles < 64) begin
         @(posedge clk);
         cycles++;
         #1;
         if (PrRdy) begin
            PrReq  = 1'b0;
            DevAck = 2'b00;
            got    = 1;
            e      = sb.pop_front();
            check({tag, " rd"},   PrRD,   e.rd);
            check({tag, " err"},  PrErr,  e.err);
            check({tag, " lat"},  cycles, e.lat);
            check({tag, " acc"},  acc,    exp_acc);
            check({tag, " sel@rdy"}, DevSel, 2'b00);
         end else if (DevSel != 2'b00) begin
            acc++;
            if (acc == 1) begin
               check({tag, " sel"},   DevSel,  exp_sel);
               check({tag, " we"},    DevWe,   we);
               check({tag, " daddr"}, DevAddr, addr[3:0]);
               check({tag, " dwd"},   DevWD,   wd);
               if (drop_req) PrReq = 1'b0;
            end
            DevAck = (acc > waits) ? ack_mask : 2'b00;
         end
      end
      if (!got) begin
         PrReq = 1'b0;
         check({tag, " rdy timeout"}, 1'b0, 1'b1);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      int rdy_seen;
      rst    = 1'b1;
      PrReq  = 1'b0;
      PrWe   = 1'b0;
      PrAddr = '0;
      PrWD   = '0;
      DevRD  = {32'hCAFE_BABE, 32'h1111_1111};
      DevAck = 2'b00;
      DevInt = 2'b00;
      #1;
      check("reset state", {PrRD, PrRdy, PrErr, DevSel, DevWe, DevAddr}, '0);
      check("reset dwd", DevWD, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      run_req("wr 7F04",   1'b1, 32'h7F04, 32'h1234_5678, 2'b01, 0, 1'b0, 2'b01, 1, 32'h0, 1'b0, 2);
      run_req("rd 7F18",   1'b0, 32'h7F18, 32'h0,         2'b10, 3, 1'b1, 2'b10, 4, 32'hCAFE_BABE, 1'b0, 5);
      check("rd hold", PrRD, 32'hCAFE_BABE);
      run_req("bad id",    1'b0, 32'h7F30, 32'h0, 2'b11, 0, 1'b0, 2'b00, 0, 32'h0, 1'b1, 1);
      run_req("misalign",  1'b0, 32'h7F02, 32'h0, 2'b11, 0, 1'b0, 2'b00, 0, 32'h0, 1'b1, 1);
      run_req("below",     1'b0, 32'h1000, 32'h0, 2'b11, 0, 1'b0, 2'b00, 0, 32'h0, 1'b1, 1);
      run_req("high bits", 1'b0, 32'h8F00, 32'h0, 2'b11, 0, 1'b0, 2'b00, 0, 32'h0, 1'b1, 1);
      run_req("timeout",   1'b0, 32'h7F00, 32'h0, 2'b00, 0, 1'b0, 2'b01, 15, 32'h0, 1'b1, 16);
      run_req("wrong ack", 1'b0, 32'h7F14, 32'h0, 2'b01, 0, 1'b0, 2'b10, 15, 32'h0, 1'b1, 16);
      run_req("rd 7F0C",   1'b0, 32'h7F0C, 32'h0, 2'b01, 1, 1'b0, 2'b01, 2, 32'h1111_1111, 1'b0, 3);

      // Reset during the second ACCESS cycle of a write.
      @(negedge clk);
      PrReq  = 1'b1;
      PrWe   = 1'b1;
      PrAddr = 32'h7F08;
      PrWD   = 32'hA5A5_5A5A;
      DevAck = 2'b00;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      check("pre-rst we",  DevWe,  1'b1);
      check("pre-rst sel", DevSel, 2'b01);
      rst = 1'b1;
      #1;
      check("rst sel", DevSel, 2'b00);
      check("rst we",  DevWe,  1'b0);
      check("rst out", {PrRD, PrRdy, PrErr, DevAddr}, '0);
      check("rst dwd", DevWD, 32'd0);
      PrReq    = 1'b0;
      rdy_seen = 0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         if (PrRdy) rdy_seen++;
      end
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #1;
         if (PrRdy) rdy_seen++;
      end
      check("rst no rdy", rdy_seen, 0);
      run_req("post-rst wr", 1'b1, 32'h7F1C, 32'hDEAD_BEEF, 2'b10, 0, 1'b0, 2'b10, 1, 32'h0, 1'b0, 2);

      // Interrupt pass-through / synchronizer.
      @(negedge clk);
      DevInt = 2'b10;
      #1;
`ifdef SYS_BRIDGE_INT_SYNC_EN
      check("int t0", HWInt, 2'b00);
      @(posedge clk);
      #1;
      check("int t1", HWInt, 2'b00);
      @(posedge clk);
      #1;
      check("int t2", HWInt, 2'b10);
`else
      check("int t0", HWInt, 2'b10);
      @(posedge clk);
      #1;
      check("int t1", HWInt, 2'b10);
      @(posedge clk);
      #1;
      check("int t2", HWInt, 2'b10);
`endif
      @(negedge clk);
      DevInt = 2'b00;
      repeat (3) @(posedge clk);
      #1;
      check("int clear", HWInt, 2'b00);
      check("sb empty", sb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
